// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared state type and timing-derivation helpers for the VGA timing generator
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } vga_state_e;

  // Full period of one axis: sync + back porch + lead border + valid + trail border + front porch.
  function automatic int calc_total(input int sync_len, input int back_len, input int lead_len,
                                    input int valid_len, input int trail_len, input int front_len);
    return sync_len + back_len + lead_len + valid_len + trail_len + front_len;
  endfunction

  // First counter value of active video on an axis.
  function automatic int calc_act(input int sync_len, input int back_len, input int lead_len);
    return sync_len + back_len + lead_len;
  endfunction

  // First counter value of the border region on an axis.
  function automatic int calc_brd(input int sync_len, input int back_len);
    return sync_len + back_len;
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// rtl/vga_axis_cnt.sv - wrapping counter with enable and terminal-count flag
// Ports: clk, rst (sync active-high), en (advance), cnt (current value), tc (en and cnt==MAX).
module vga_axis_cnt #(
  parameter int W   = 11,
  parameter int MAX = 799
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    tc    = en && (cnt_q == MAX_C);
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (cnt_q == MAX_C) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing generator with frame-aligned start/stop
// Ports: vga_clk, sys_rst (sync active-high), en (run request), border_color, pix_data (in);
//        pix_req, pix_x, pix_y (pixel request, combinational from counters);
//        hsync, vsync, de, rgb (registered display outputs); frame_start, busy (status).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_SYNC   = 96,
  parameter int   H_BACK   = 40,
  parameter int   H_LEFT   = 8,
  parameter int   H_VALID  = 640,
  parameter int   H_RIGHT  = 8,
  parameter int   H_FRONT  = 8,
  parameter int   V_SYNC   = 2,
  parameter int   V_BACK   = 25,
  parameter int   V_TOP    = 8,
  parameter int   V_VALID  = 480,
  parameter int   V_BOTTOM = 8,
  parameter int   V_FRONT  = 2,
  parameter logic H_POL    = 1'b1,
  parameter logic V_POL    = 1'b1,
  parameter int   REQ_LEAD = 1,
  parameter int   COLOR_W  = 12,
  parameter int   CNT_W    = 11
) (
  input  logic               vga_clk,
  input  logic               sys_rst,
  input  logic               en,
  input  logic [COLOR_W-1:0] border_color,
  input  logic [COLOR_W-1:0] pix_data,
  output logic               pix_req,
  output logic [CNT_W-1:0]   pix_x,
  output logic [CNT_W-1:0]   pix_y,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COLOR_W-1:0] rgb,
  output logic               frame_start,
  output logic               busy
);

  localparam int H_TOTAL = calc_total(H_SYNC, H_BACK, H_LEFT, H_VALID, H_RIGHT, H_FRONT);
  localparam int H_ACT   = calc_act(H_SYNC, H_BACK, H_LEFT);
  localparam int H_BRD   = calc_brd(H_SYNC, H_BACK);
  localparam int V_TOTAL = calc_total(V_SYNC, V_BACK, V_TOP, V_VALID, V_BOTTOM, V_FRONT);
  localparam int V_ACT   = calc_act(V_SYNC, V_BACK, V_TOP);
  localparam int V_BRD   = calc_brd(V_SYNC, V_BACK);

  // Counter-width copies of every region boundary so comparisons stay width-matched.
  localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] H_BRD_C   = CNT_W'(H_BRD);
  localparam logic [CNT_W-1:0] H_ACT_C   = CNT_W'(H_ACT);
  localparam logic [CNT_W-1:0] H_END_C   = CNT_W'(H_ACT + H_VALID);
  localparam logic [CNT_W-1:0] H_BEND_C  = CNT_W'(H_ACT + H_VALID + H_RIGHT);
  localparam logic [CNT_W-1:0] H_REQ_C   = CNT_W'(H_ACT - REQ_LEAD);
  localparam logic [CNT_W-1:0] H_REQE_C  = CNT_W'(H_ACT + H_VALID - REQ_LEAD);
  localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] V_BRD_C   = CNT_W'(V_BRD);
  localparam logic [CNT_W-1:0] V_ACT_C   = CNT_W'(V_ACT);
  localparam logic [CNT_W-1:0] V_END_C   = CNT_W'(V_ACT + V_VALID);
  localparam logic [CNT_W-1:0] V_BEND_C  = CNT_W'(V_ACT + V_VALID + V_BOTTOM);

  vga_state_e         state_q, state_d;
  logic               running;
  logic [CNT_W-1:0]   cnt_h, cnt_v;
  logic               h_tc, v_tc;
  logic               h_act, v_act, h_brd, v_brd, active, border;
  logic               hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [COLOR_W-1:0] rgb_q, rgb_d;

  assign running = (state_q != IDLE);

  vga_axis_cnt #(.W(CNT_W), .MAX(H_TOTAL - 1)) u_cnt_h (
    .clk (vga_clk),
    .rst (sys_rst),
    .en  (running),
    .cnt (cnt_h),
    .tc  (h_tc)
  );

  vga_axis_cnt #(.W(CNT_W), .MAX(V_TOTAL - 1)) u_cnt_v (
    .clk (vga_clk),
    .rst (sys_rst),
    .en  (h_tc),
    .cnt (cnt_v),
    .tc  (v_tc)
  );

  // v_tc is only high on the last pixel of a frame while the counters run.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = DRAIN;
      DRAIN:   if (en) state_d = RUN;
               else if (v_tc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    h_act  = (cnt_h >= H_ACT_C) && (cnt_h < H_END_C);
    v_act  = (cnt_v >= V_ACT_C) && (cnt_v < V_END_C);
    h_brd  = (cnt_h >= H_BRD_C) && (cnt_h < H_BEND_C);
    v_brd  = (cnt_v >= V_BRD_C) && (cnt_v < V_BEND_C);
    active = h_act && v_act;
    border = h_brd && v_brd && !active;

    hsync_d = (running && (cnt_h < H_SYNC_C)) ? H_POL : ~H_POL;
    vsync_d = (running && (cnt_v < V_SYNC_C)) ? V_POL : ~V_POL;
    de_d    = running && active;
    rgb_d   = '0;
    if (running && active) begin
      rgb_d = pix_data;
    end else if (running && border) begin
      rgb_d = border_color;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      de_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      rgb_q   <= rgb_d;
    end
  end

  // Requests lead active video by the source latency so data lands exactly on the active column.
  assign pix_req = running && (cnt_h >= H_REQ_C) && (cnt_h < H_REQE_C) && v_act;
  assign pix_x   = pix_req ? (cnt_h - H_REQ_C) : '1;
  assign pix_y   = pix_req ? (cnt_v - V_ACT_C) : '1;

  assign frame_start = running && (cnt_h == '0) && (cnt_v == '0);
  assign busy        = running;

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign de    = de_q;
  assign rgb   = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized self-checking bench against a frame-position reference model
module tb_vga_timing_gen;

  localparam int HS = 4, HB = 3, HL = 2, HV = 10, HR = 2, HF = 3;
  localparam int VS = 2, VB = 2, VT = 1, VV = 6, VBT = 1, VF = 2;
  localparam int L = 3;
  localparam logic HPOL = 1'b0;
  localparam logic VPOL = 1'b1;
  localparam int CW = 6;
  localparam int HT = HS + HB + HL + HV + HR + HF;
  localparam int VTOT = VS + VB + VT + VV + VBT + VF;
  localparam int HA = HS + HB + HL;
  localparam int HBRD = HS + HB;
  localparam int VA = VS + VB + VT;
  localparam int VBRD = VS + VB;
  localparam int FRAME = HT * VTOT;
  localparam int ONES = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          en = 1'b0;
  logic [11:0]   border_color = '0;
  logic [11:0]   pix_data = '0;
  logic          pix_req;
  logic [CW-1:0] pix_x, pix_y;
  logic          hsync, vsync, de, frame_start, busy;
  logic [11:0]   rgb;

  vga_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_LEFT(HL), .H_VALID(HV), .H_RIGHT(HR), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_TOP(VT), .V_VALID(VV), .V_BOTTOM(VBT), .V_FRONT(VF),
    .H_POL(HPOL), .V_POL(VPOL), .REQ_LEAD(L), .COLOR_W(12), .CNT_W(CW)
  ) dut (
    .vga_clk(clk), .sys_rst(sys_rst), .en(en), .border_color(border_color),
    .pix_data(pix_data), .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
    .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb),
    .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_on  = 0;

  // Reference model: running flag, pending-stop flag, and linear position within the frame.
  bit          m_run = 0;
  bit          m_stop = 0;
  int          m_pos = 0;
  logic        e_hs = ~HPOL, e_vs = ~VPOL, e_de = 1'b0;
  logic [11:0] e_rgb = '0;

  // Pixel source: data for a request becomes valid L cycles later.
  logic [11:0] pipe [8];
  bit          pipe_v [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [11:0] pix_fn(input int x, input int y);
    int t;
    t = x * 37 + y * 101 + 5;
    return t[11:0];
  endfunction

  task automatic step(input bit en_v, input bit rst_v);
    int h, v, slot;
    bit req, act, brd, last;
    logic [11:0] bc;
    @(negedge clk);
    sys_rst = rst_v;
    en = en_v;
    bc = 12'($urandom);
    border_color = bc;
    slot = cyc % 8;
    pix_data = pipe_v[slot] ? pipe[slot] : 12'($urandom);
    pipe_v[slot] = 0;
    #1;
    h = m_pos % HT;
    v = m_pos / HT;
    if (chk_on) begin
      req = m_run && (h >= HA - L) && (h < HA + HV - L) && (v >= VA) && (v < VA + VV);
      check("busy", 32'(busy), 32'(m_run));
      check("frame_start", 32'(frame_start), 32'(m_run && m_pos == 0));
      check("pix_req", 32'(pix_req), 32'(req));
      check("pix_x", 32'(pix_x), req ? h - (HA - L) : ONES);
      check("pix_y", 32'(pix_y), req ? v - VA : ONES);
      check("hsync", 32'(hsync), 32'(e_hs));
      check("vsync", 32'(vsync), 32'(e_vs));
      check("de", 32'(de), 32'(e_de));
      check("rgb", 32'(rgb), 32'(e_rgb));
    end
    if (pix_req === 1'b1) begin
      pipe[(cyc + L) % 8]   = pix_fn(int'(pix_x), int'(pix_y));
      pipe_v[(cyc + L) % 8] = 1;
    end
    @(posedge clk);
    if (rst_v) begin
      m_run = 0; m_stop = 0; m_pos = 0;
      e_hs = ~HPOL; e_vs = ~VPOL; e_de = 1'b0; e_rgb = '0;
      chk_on = 1;
    end else begin
      act = (h >= HA) && (h < HA + HV) && (v >= VA) && (v < VA + VV);
      brd = (h >= HBRD) && (h < HA + HV + HR) && (v >= VBRD) && (v < VA + VV + VBT);
      e_hs  = (m_run && h < HS) ? HPOL : ~HPOL;
      e_vs  = (m_run && v < VS) ? VPOL : ~VPOL;
      e_de  = m_run && act;
      e_rgb = !m_run ? 12'h0 : act ? pix_fn(h - HA, v - VA) : brd ? bc : 12'h0;
      if (!m_run) begin
        if (en_v) begin
          m_run = 1;
          m_pos = 0;
        end
      end else begin
        last  = (m_pos == FRAME - 1);
        m_pos = (m_pos + 1) % FRAME;
        if (!en_v && m_stop && last) begin
          m_run = 0;
          m_stop = 0;
        end else begin
          m_stop = !en_v;
        end
      end
    end
    cyc++;
  endtask

  task automatic run(input int n, input bit en_v);
    for (int i = 0; i < n; i++) step(en_v, 1'b0);
  endtask

  // Keep en high until the model reaches the start of the given line.
  task automatic run_to_line(input int line);
    int guard = 0;
    while (!(m_run && m_pos == line * HT) && guard < 2 * FRAME) begin
      step(1'b1, 1'b0);
      guard++;
    end
    check("reach_line", 32'(guard < 2 * FRAME), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      pipe_v[i] = 0;
      pipe[i] = '0;
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    run(100, 1'b0);
    run(2 * FRAME + 5, 1'b1);
    // Stop request withdrawn mid-frame: frame continues, busy stays high.
    run_to_line(5);
    run(3 * HT, 1'b0);
    run(FRAME, 1'b1);
    // Stop request held: drains to end of frame, idles, then restarts at the origin.
    run_to_line(5);
    run(FRAME, 1'b0);
    run(FRAME + 20, 1'b1);
    // Stop request on the very last pixel of a frame.
    run_to_line(VTOT - 1);
    run(HT - 1, 1'b1);
    run(FRAME + 30, 1'b0);
    // Randomized run/stop segments.
    for (int s = 0; s < 25; s++) begin
      run($urandom_range(1, 400), 1'($urandom_range(0, 1)));
    end
    // Reset in the middle of a running frame.
    run_to_line(3);
    run($urandom_range(1, HT), 1'b1);
    step(1'b1, 1'b1);
    run(FRAME + 10, 1'b1);
    run(2 * FRAME, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator and pixel pipeline front end. It replaces the fixed-640×480 controller:
- Horizontal and vertical timing, sync polarity, colour width and pixel-source latency are parameters.
- Start/stop is frame-aligned via a small state machine.
- All display outputs are registered.

It sits between the pixel source (pattern generator, frame buffer reader) and the DAC/connector pins, on the `vga_clk` domain.

## Interface
Parameters:
- `H_SYNC`, `H_BACK`, `H_LEFT`, `H_VALID`, `H_RIGHT`, `H_FRONT`: defaults 96, 40, 8, 640, 8, 8. Horizontal segment lengths in pixels, in this order.
- `V_SYNC`, `V_BACK`, `V_TOP`, `V_VALID`, `V_BOTTOM`, `V_FRONT`: defaults 2, 25, 8, 480, 8, 2. Vertical segment lengths in lines.
- `H_POL`, `V_POL`: default 1. Sync active level; 1 = active-high.
- `REQ_LEAD`: default 1. Fixed pixel-source latency in clocks, range 1..(H_BACK+H_LEFT).
- `COLOR_W`: default 12. RGB width.
- `CNT_W`: default 11. Counter and coordinate width; must hold H_TOTAL-1 and V_TOTAL-1.

Ports:
- `vga_clk` in 1: pixel clock. One clock; reset is synchronous and active-high.
- `sys_rst` in 1: synchronous, active-high reset.
- `en` in 1: run request, level-sensitive.
- `border_color` in COLOR_W: colour driven during left/right/top/bottom border.
- `pix_data` in COLOR_W: pixel colour, valid exactly REQ_LEAD clocks after its `pix_req`.
- `pix_req` out 1: pixel request.
- `pix_x` out CNT_W: requested pixel column.
- `pix_y` out CNT_W: requested pixel row.
- `hsync` out 1: registered line sync.
- `vsync` out 1: registered frame sync.
- `de` out 1: registered active-video flag.
- `rgb` out COLOR_W: registered colour.
- `frame_start` out 1: one-clock pulse at h=0, v=0 while running.
- `busy` out 1: high in RUN and DRAIN.

## Operation
- Derived constants:
  - H_TOTAL = sum of the six H segments; H_ACT = H_SYNC+H_BACK+H_LEFT; H_BRD = H_SYNC+H_BACK.
  - V_TOTAL, V_ACT and V_BRD are defined the same way.
- Counters:
  - `cnt_h` runs 0..H_TOTAL-1 and wraps to 0.
  - `cnt_v` increments when `cnt_h` wraps and itself wraps to 0 at V_TOTAL-1.
  - Both counters advance only in RUN and DRAIN.
- State machine:
  - IDLE: counters held at 0, no requests, outputs at blank levels.
  - IDLE→RUN: on `en`=1. Counters start from 0 on the next clock, so the first running cycle is h=0, v=0.
  - RUN→DRAIN: on `en`=0.
  - DRAIN→RUN: `en` returns to 1 before the frame ends; the frame continues uninterrupted.
  - DRAIN→IDLE: on the last pixel of the frame (h=H_TOTAL-1, v=V_TOTAL-1), unless `en`=1 in that same cycle; in that case go to RUN. Frames are never truncated.
- Request window: `pix_req`=1 when running and H_ACT-REQ_LEAD ≤ `cnt_h` < H_ACT+H_VALID-REQ_LEAD and V_ACT ≤ `cnt_v` < V_ACT+V_VALID.
  - While asserted: `pix_x` = `cnt_h`-(H_ACT-REQ_LEAD), `pix_y` = `cnt_v`-V_ACT.
  - Otherwise both coordinates are all-ones.
- Region decode on the counters, all registered into the outputs:
  - Active: H_ACT ≤ h < H_ACT+H_VALID and the vertical equivalent. Drives `rgb`=`pix_data`, `de`=1.
  - Border: inside [H_BRD, H_ACT+H_VALID+H_RIGHT) × [V_BRD, V_ACT+V_VALID+V_BOTTOM) but not active. Drives `rgb`=`border_color`, `de`=0.
  - Everywhere else: `rgb`=0, `de`=0.
- Sync levels:
  - `hsync` = H_POL when h < H_SYNC, else ~H_POL.
  - `vsync` = V_POL when v < V_SYNC, else ~V_POL.
  - In IDLE both syncs sit at their inactive level.

## Timing
- Reset values:
  - State IDLE; `cnt_h` = `cnt_v` = 0.
  - `hsync` = ~H_POL, `vsync` = ~V_POL.
  - `rgb` = 0, `de` = 0, `pix_req` = 0, `pix_x` = `pix_y` = all-ones, `frame_start` = 0, `busy` = 0.
- Reset mid-frame returns to IDLE on the next edge, with no partial-frame completion.
- Output latency is 1 clock from counter state to `hsync`/`vsync`/`de`/`rgb`. The four outputs are mutually aligned.
- `pix_req` for column k is issued at h=H_ACT+k-REQ_LEAD. `pix_data` is sampled at h=H_ACT+k and appears on `rgb` one clock later, together with `de`=1.
- `frame_start` is combinational from the counters and asserted at h=0, v=0, one clock before the matching registered `vsync` edge.

## Structure
- Package `vga_pkg`:
  - State enum {IDLE, RUN, DRAIN}.
  - Functions deriving H_TOTAL, H_ACT, H_BRD and V_TOTAL, V_ACT, V_BRD from the segment parameters.
- Sub-module `vga_axis_cnt`: a wrapping counter with enable, terminal-count output and parameter MAX. It is instantiated twice, horizontally (enable = running) and vertically (enable = horizontal terminal count).
- Top level holds the FSM, region decode and output registers.

## Test plan
- Reset, then `en`=0 for 100 clocks → every output holds its reset value; `hsync`=`vsync`=0 with default polarity inverted.
- Default parameters, `en`=1:
  - Line period is 800 clocks and frame period 420000.
  - `hsync` is high for 96 clocks; `vsync` is high for 1600 clocks.
  - `frame_start` pulses every 420000 clocks.
- REQ_LEAD=3, source echoes `pix_data`=`pix_x` after 3 clocks:
  - First `pix_req` is at h=141 with `pix_x`=0, `pix_y`=0.
  - `rgb`=0 with `de`=1 one clock after h=144.
  - `rgb`=639 on the last active pixel; 640 requests per line, 480 lines.
- `border_color`=12'hABC → `rgb`=ABC with `de`=0 at h=136..143 and h=784..791 on active lines, and across rows 27..34; `rgb`=0 in the sync and porch regions.
- Drop `en` at line 200, then raise it again at line 300 → frame completes without a gap and `busy` stays 1. Drop `en` at line 200 and keep it low → `busy` falls right after the last pixel of the frame, outputs return to blank, and the next `en` restarts at h=0, v=0.
- H_POL=0, V_POL=0 with small timing (4, 2, 1, 8, 1, 2 / 1, 1, 1, 4, 1, 1) → `hsync` is low for exactly 4 clocks per 18-clock line and `vsync` is low for 18 clocks per 9-line frame.
